// File: rtl/shift_ext_unit.sv
// ============================================================================
// Module   : shift_ext_unit
// Purpose  : One-cycle immediate extension plus iterative shift (STEP bits/cycle)
//            with start/busy/done handshake. Define SHIFT_EXT_ROR_EN to enable
//            op 111 as rotate-right; otherwise op 111 returns 0 in one cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_ext_unit #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16,
  parameter int STEP  = 1,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] src,
  input  logic [SH_W-1:0]  shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] KIND_SLL = 2'b00;
  localparam logic [1:0] KIND_SRL = 2'b01;
  localparam logic [1:0] KIND_SRA = 2'b10;

  localparam logic [SH_W:0] STEP_V = (SH_W+1)'(STEP);

  state_t           state, state_next;
  logic [WIDTH-1:0] work, work_next;
  logic [SH_W-1:0]  remaining, remaining_next;
  logic [1:0]       kind, kind_next;
  logic             sign_fill, sign_fill_next;
  logic [WIDTH-1:0] result_next;
  logic             done_next, busy_next;

  logic [SH_W-1:0]  step_amt;
  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] sext_val;
  logic [WIDTH-1:0] ext_val;

  // Final step may be shorter than STEP when shamt is not a multiple of it.
  always_comb begin
    step_amt = ({1'b0, remaining} >= STEP_V) ? STEP_V[SH_W-1:0] : remaining;
  end

`ifdef SHIFT_EXT_ROR_EN
  localparam logic [SH_W:0] WIDTH_V = (SH_W+1)'(WIDTH);
  logic [SH_W:0] rot_amt;
  always_comb begin
    rot_amt = WIDTH_V - {1'b0, step_amt};
  end
`endif

  always_comb begin
    fill_mask = ~({WIDTH{1'b1}} >> step_amt);
    case (kind)
      KIND_SLL: shifted = work << step_amt;
      KIND_SRL: shifted = work >> step_amt;
      KIND_SRA: shifted = (work >> step_amt) | (sign_fill ? fill_mask : '0);
`ifdef SHIFT_EXT_ROR_EN
      default:  shifted = (work >> step_amt) | (work << rot_amt);
`else
      default:  shifted = '0;
`endif
    endcase
  end

  always_comb begin
    sext_val = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    case (op[1:0])
      2'b00:   ext_val = {{(WIDTH-IMM_W){1'b0}}, imm};
      2'b01:   ext_val = sext_val;
      2'b10:   ext_val = sext_val << 2;
      default: ext_val = {imm, {(WIDTH-IMM_W){1'b0}}};
    endcase
  end

  always_comb begin
    state_next     = state;
    work_next      = work;
    remaining_next = remaining;
    kind_next      = kind;
    sign_fill_next = sign_fill;
    result_next    = result;
    done_next      = 1'b0;
    busy_next      = busy;

    case (state)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            result_next = ext_val;
            done_next   = 1'b1;
`ifndef SHIFT_EXT_ROR_EN
          end else if (op == 3'b111) begin
            result_next = '0;
            done_next   = 1'b1;
`endif
          end else if (shamt == '0) begin
            result_next = src;
            done_next   = 1'b1;
          end else begin
            work_next      = src;
            remaining_next = shamt;
            kind_next      = op[1:0];
            sign_fill_next = src[WIDTH-1];
            busy_next      = 1'b1;
            state_next     = SHIFT;
          end
        end
      end
      default: begin
        work_next      = shifted;
        remaining_next = remaining - step_amt;
        if (remaining_next == '0) begin
          result_next = shifted;
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      kind      <= '0;
      sign_fill <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      work      <= work_next;
      remaining <= remaining_next;
      kind      <= kind_next;
      sign_fill <= sign_fill_next;
      result    <= result_next;
      done      <= done_next;
      busy      <= busy_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_ext_unit.sv
// ============================================================================
// Module   : tb_shift_ext_unit
// Purpose  : Self-checking bench; two DUT instances (STEP=1 and STEP=4) share
//            stimulus and are checked against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_ext_unit;

  localparam int WIDTH = 32;
  localparam int IMM_W = 16;
  localparam int SH_W  = 5;
  localparam int WIN   = 40;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [2:0]        op;
  logic [IMM_W-1:0]  imm;
  logic [WIDTH-1:0]  src;
  logic [SH_W-1:0]   shamt;
  logic              busy1, done1, busy4, done4;
  logic [WIDTH-1:0]  result1, result4;

  int compared   = 0;
  int mismatched = 0;

  // Measurements from the last launch, index 0 = STEP 1, index 1 = STEP 4.
  int              steps[2] = '{1, 4};
  logic [WIDTH-1:0] m_res[2];
  int              m_dcnt[2], m_dfirst[2], m_bcnt[2];

  always #5 clk = ~clk;

  shift_ext_unit #(.WIDTH(WIDTH), .IMM_W(IMM_W), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .imm(imm), .src(src),
    .shamt(shamt), .busy(busy1), .done(done1), .result(result1)
  );

  shift_ext_unit #(.WIDTH(WIDTH), .IMM_W(IMM_W), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .imm(imm), .src(src),
    .shamt(shamt), .busy(busy4), .done(done4), .result(result4)
  );

  function automatic logic [31:0] model_result(logic [2:0] o, logic [15:0] i,
                                               logic [31:0] s, logic [4:0] sh);
    logic [31:0] sx;
    sx = {{16{i[15]}}, i};
    case (o)
      3'd0: return {16'h0000, i};
      3'd1: return sx;
      3'd2: return sx * 4;
      3'd3: return {i, 16'h0000};
      3'd4: return s << sh;
      3'd5: return s >> sh;
      3'd6: return 32'($signed(s) >>> sh);
      default: begin
`ifdef SHIFT_EXT_ROR_EN
        if (sh == 0) return s;
        return (s >> sh) | (s << (32 - int'(sh)));
`else
        return 32'h0;
`endif
      end
    endcase
  endfunction

  function automatic int model_lat(logic [2:0] o, logic [4:0] sh, int step);
    if (!o[2] || sh == 0) return 0;
`ifndef SHIFT_EXT_ROR_EN
    if (o == 3'b111) return 0;
`endif
    return (int'(sh) + step - 1) / step;
  endfunction

  // Issues one request, scrambles operands after the accept edge, and records
  // done/busy behaviour of both instances over a fixed window.
  task automatic launch_and_watch(input logic [2:0] o, input logic [15:0] i,
                                  input logic [31:0] s, input logic [4:0] sh,
                                  input bit inject);
    @(negedge clk);
    op = o; imm = i; src = s; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); imm = 16'($urandom); src = $urandom; shamt = 5'($urandom);
    for (int d = 0; d < 2; d++) begin
      m_dcnt[d] = 0; m_dfirst[d] = 0; m_bcnt[d] = 0;
    end
    for (int j = 1; j <= WIN; j++) begin
      if (done1) begin m_dcnt[0]++; if (m_dfirst[0] == 0) m_dfirst[0] = j; end
      if (done4) begin m_dcnt[1]++; if (m_dfirst[1] == 0) m_dfirst[1] = j; end
      if (busy1) m_bcnt[0]++;
      if (busy4) m_bcnt[1]++;
      if (inject && j == 1) start = 1'b1;
      if (inject && j == 2) start = 1'b0;
      if (j < WIN) begin @(posedge clk); #1; end
    end
    m_res[0] = result1;
    m_res[1] = result4;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = '0; imm = '0; src = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({busy1, done1, busy4, done4} !== 4'b0000 || result1 !== '0 || result4 !== '0) begin
      mismatched++;
      $display("FAIL reset_state: busy/done=%b res1=%h res4=%h, want 0000/0/0",
               {busy1, done1, busy4, done4}, result1, result4);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [15:0] i;
    logic [31:0] s;
    logic [4:0]  sh;
    logic [31:0] exp;
  } dcase_t;

  task automatic test_directed;
    dcase_t tbl[8];
    tbl[0] = '{3'd2, 16'h8001, 32'h0, 5'd0, 32'hFFFE0004};
    tbl[1] = '{3'd0, 16'h8001, 32'h0, 5'd0, 32'h00008001};
    tbl[2] = '{3'd3, 16'h1234, 32'h0, 5'd0, 32'h12340000};
    tbl[3] = '{3'd6, 16'h0, 32'h80000000, 5'd31, 32'hFFFFFFFF};
    tbl[4] = '{3'd5, 16'h0, 32'h80000000, 5'd31, 32'h00000001};
    tbl[5] = '{3'd4, 16'h0, 32'h00000001, 5'd9, 32'h00000200};
    tbl[6] = '{3'd4, 16'h0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF};
`ifdef SHIFT_EXT_ROR_EN
    tbl[7] = '{3'd7, 16'h0, 32'h00000001, 5'd4, 32'h10000000};
`else
    tbl[7] = '{3'd7, 16'h0, 32'h00000001, 5'd4, 32'h00000000};
`endif
    for (int c = 0; c < 8; c++) begin
      launch_and_watch(tbl[c].o, tbl[c].i, tbl[c].s, tbl[c].sh, 1'b0);
      for (int d = 0; d < 2; d++) begin
        int lat;
        lat = model_lat(tbl[c].o, tbl[c].sh, steps[d]);
        compared++;
        if (m_res[d] !== tbl[c].exp || m_dcnt[d] != 1 || m_dfirst[d] != lat + 1 ||
            m_bcnt[d] != lat) begin
          mismatched++;
          $display("FAIL directed[%0d] step%0d: res=%h done#=%0d at=%0d busy=%0d, want res=%h done#=1 at=%0d busy=%0d",
                   c, steps[d], m_res[d], m_dcnt[d], m_dfirst[d], m_bcnt[d],
                   tbl[c].exp, lat + 1, lat);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    op = 3'd3; imm = 16'h1234; start = 1'b1;
    @(posedge clk); #1;
    op = 3'd1; imm = 16'hFFFF;
    compared++;
    if (!(done1 && done4) || result1 !== 32'h12340000 || result4 !== 32'h12340000) begin
      mismatched++;
      $display("FAIL b2b_first: done=%b%b res=%h/%h, want 11 12340000", done1, done4, result1, result4);
    end
    @(posedge clk); #1;
    start = 1'b0;
    compared++;
    if (!(done1 && done4) || result1 !== 32'hFFFFFFFF || result4 !== 32'hFFFFFFFF) begin
      mismatched++;
      $display("FAIL b2b_second: done=%b%b res=%h/%h, want 11 ffffffff", done1, done4, result1, result4);
    end
    @(posedge clk); #1;
    compared++;
    if (done1 || done4 || result1 !== 32'hFFFFFFFF || result4 !== 32'hFFFFFFFF) begin
      mismatched++;
      $display("FAIL b2b_after: done=%b%b res=%h/%h, want 00 ffffffff", done1, done4, result1, result4);
    end
  endtask

  task automatic test_busy_ignore;
    launch_and_watch(3'd4, 16'h0, 32'h00000001, 5'd9, 1'b1);
    for (int d = 0; d < 2; d++) begin
      int lat;
      lat = (9 + steps[d] - 1) / steps[d];
      compared++;
      if (m_res[d] !== 32'h00000200 || m_dcnt[d] != 1 || m_dfirst[d] != lat + 1 ||
          m_bcnt[d] != lat) begin
        mismatched++;
        $display("FAIL busy_ignore step%0d: res=%h done#=%0d at=%0d busy=%0d, want 00000200 1 %0d %0d",
                 steps[d], m_res[d], m_dcnt[d], m_dfirst[d], m_bcnt[d], lat + 1, lat);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    int dc;
    @(negedge clk);
    op = 3'd6; src = 32'h80000000; shamt = 5'd31; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    compared++;
    if ({busy1, done1, busy4, done4} !== 4'b0000 || result1 !== '0 || result4 !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_op: busy/done=%b res=%h/%h, want 0000 0/0",
               {busy1, done1, busy4, done4}, result1, result4);
    end
    dc = 0;
    for (int j = 0; j < WIN; j++) begin
      @(posedge clk); #1;
      if (done1 || done4 || busy1 || busy4) dc++;
    end
    compared++;
    if (dc != 0) begin
      mismatched++;
      $display("FAIL reset_no_late_done: %0d cycles with done/busy, want 0", dc);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      logic [2:0]  o;
      logic [15:0] i;
      logic [31:0] s;
      logic [4:0]  sh;
      logic [31:0] exp;
      o = 3'($urandom_range(0, 7));
      i = 16'($urandom);
      s = $urandom;
      sh = 5'($urandom);
      exp = model_result(o, i, s, sh);
      launch_and_watch(o, i, s, sh, 1'b0);
      for (int d = 0; d < 2; d++) begin
        int lat;
        lat = model_lat(o, sh, steps[d]);
        compared++;
        if (m_res[d] !== exp || m_dcnt[d] != 1 || m_dfirst[d] != lat + 1 || m_bcnt[d] != lat) begin
          mismatched++;
          $display("FAIL random[%0d] op=%0d step%0d: res=%h done#=%0d at=%0d busy=%0d, want res=%h done#=1 at=%0d busy=%0d",
                   n, o, steps[d], m_res[d], m_dcnt[d], m_dfirst[d], m_bcnt[d], exp, lat + 1, lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
